// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, FSM states and command record for the calc sequencer
package calc_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_GND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;
    localparam logic [3:0] OP_PRE = 4'b1110;
    localparam logic [3:0] OP_RES = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] in1;
    } cmd_t;

    // Overflow only matters for add/sub, divide-by-zero only for div/mod.
    function automatic logic [1:0] res_err_mask(input logic [3:0] op, input logic [1:0] err);
        logic [1:0] m;
        m[0] = err[0] && ((op == OP_ADD) || (op == OP_SUB));
        m[1] = err[1] && ((op == OP_DIV) || (op == OP_MOD));
        return m;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - host, datapath and result signals of the calc sequencer
interface calc_sequencer_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [3:0]  CMD_OP;
    logic [15:0] CMD_IN1;
    logic [3:0]  BB_OP;
    logic [15:0] BB_IN1;
    logic [31:0] BB_OUT;
    logic [1:0]  BB_ERR;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_ERR;
    logic        BUSY;
    logic        HALT;
    logic        CLR_HALT;

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_IN1, BB_OUT, BB_ERR, RES_READY, CLR_HALT,
        output CMD_READY, BB_OP, BB_IN1, RES_VALID, RES_DATA, RES_ERR, BUSY, HALT
    );

    modport master (
        output CMD_VALID, CMD_OP, CMD_IN1, BB_OUT, BB_ERR, RES_READY, CLR_HALT,
        input  CMD_READY, BB_OP, BB_IN1, RES_VALID, RES_DATA, RES_ERR, BUSY, HALT
    );
endinterface

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - command FIFO with full/empty/count
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     wdata,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - issues queued commands to the accumulator datapath one at a time
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1
) (
    input logic              CLK,
    input logic              RST,
    calc_sequencer_if.slave  bus
);
    localparam logic [2:0] WAIT_LAST = 3'(SETTLE - 1);

    state_t                  state;
    state_t                  state_next;
    cmd_t                    fifo_head;
    cmd_t                    cmd_reg;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    push;
    logic                    pop;
    logic [2:0]              wait_cnt;
    logic                    wait_last;
    logic [31:0]             res_data;
    logic [1:0]              res_err;

    assign push      = bus.CMD_VALID && !fifo_full;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign wait_last = (wait_cnt == WAIT_LAST);

    calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .wdata ('{op: bus.CMD_OP, in1: bus.CMD_IN1}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state: one command in flight, errors park the FSM in HALTED.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!fifo_empty) state_next = ST_ISSUE;
            ST_ISSUE:  state_next = ST_WAIT;
            ST_WAIT:   if (wait_last) state_next = ST_HOLD;
            ST_HOLD:   if (bus.RES_READY) state_next = (res_err != 2'b00) ? ST_HALTED : ST_IDLE;
            ST_HALTED: if (bus.CLR_HALT) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Latch the popped command, count settle cycles, capture the datapath result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_reg  <= '0;
            wait_cnt <= '0;
            res_data <= '0;
            res_err  <= '0;
        end else begin
            if (pop) cmd_reg <= fifo_head;
            if (state == ST_ISSUE)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if ((state == ST_WAIT) && wait_last) begin
                res_data <= bus.BB_OUT;
                res_err  <= res_err_mask(cmd_reg.op, bus.BB_ERR);
            end
        end
    end

    // Outputs decoded from state; the datapath sees a no-op outside ISSUE.
    always_comb begin
        bus.BB_OP     = OP_NOP;
        bus.BB_IN1    = '0;
        bus.RES_VALID = 1'b0;
        bus.HALT      = 1'b0;
        bus.RES_DATA  = res_data;
        bus.RES_ERR   = res_err;
        bus.CMD_READY = !fifo_full;
        bus.BUSY      = (fifo_count != '0) || (state != ST_IDLE);
        case (state)
            ST_ISSUE: begin
                bus.BB_OP  = cmd_reg.op;
                bus.BB_IN1 = cmd_reg.in1;
            end
            ST_HOLD:   bus.RES_VALID = 1'b1;
            ST_HALTED: bus.HALT = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed bench for calc_sequencer
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic [1:0]  inj_err;
    logic [31:0] acc_a = 32'h0000_1234;
    logic [31:0] acc_b = 32'h0000_5678;
    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer_if a ();
    calc_sequencer_if b ();

    calc_sequencer #(.DEPTH(8), .SETTLE(1)) dut_a (.CLK(clk), .RST(rst_a), .bus(a));
    calc_sequencer #(.DEPTH(8), .SETTLE(3)) dut_b (.CLK(clk), .RST(rst_b), .bus(b));

    always #5 clk = ~clk;

    // Accumulator datapath stand-ins, one per sequencer.
    always_ff @(posedge clk) begin
        case (a.BB_OP)
            4'b1111: acc_a <= 32'd0;
            4'b0010: acc_a <= acc_a + 32'(a.BB_IN1);
            4'b0011: acc_a <= acc_a - 32'(a.BB_IN1);
            4'b0100: acc_a <= acc_a * 32'(a.BB_IN1);
            4'b0101: if (a.BB_IN1 != 0) acc_a <= acc_a / 32'(a.BB_IN1);
            4'b0110: if (a.BB_IN1 != 0) acc_a <= acc_a % 32'(a.BB_IN1);
            default: acc_a <= acc_a;
        endcase
    end

    always_ff @(posedge clk) begin
        case (b.BB_OP)
            4'b1111: acc_b <= 32'd0;
            4'b0010: acc_b <= acc_b + 32'(b.BB_IN1);
            default: acc_b <= acc_b;
        endcase
    end

    assign a.BB_OUT = acc_a;
    assign a.BB_ERR = inj_err;
    assign b.BB_OUT = acc_b;
    assign b.BB_ERR = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_a(input logic [3:0] op, input logic [15:0] in1);
        a.CMD_VALID = 1'b1;
        a.CMD_OP    = op;
        a.CMD_IN1   = in1;
        step();
        a.CMD_VALID = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_err);
        int n = 0;
        while (a.RES_VALID !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(a.RES_VALID), 32'd1);
        check({tag, "_data"}, a.RES_DATA, exp_data);
        check({tag, "_err"}, 32'(a.RES_ERR), 32'(exp_err));
        a.RES_READY = 1'b1;
        step();
        a.RES_READY = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepted;
        logic seen;

        a.CMD_VALID = 0; a.CMD_OP = 0; a.CMD_IN1 = 0; a.RES_READY = 0; a.CLR_HALT = 0;
        b.CMD_VALID = 0; b.CMD_OP = 0; b.CMD_IN1 = 0; b.RES_READY = 0; b.CLR_HALT = 0;
        inj_err = 2'b00;
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_res_valid", 32'(a.RES_VALID), 32'd0);
        check("rst_res_data", a.RES_DATA, 32'd0);
        check("rst_res_err", 32'(a.RES_ERR), 32'd0);
        check("rst_halt", 32'(a.HALT), 32'd0);
        check("rst_busy", 32'(a.BUSY), 32'd0);
        check("rst_cmd_ready", 32'(a.CMD_READY), 32'd1);
        check("rst_bb_op", 32'(a.BB_OP), 32'd0);

        // Scenario 1: latency of the first command, then ADD 10.
        push_a(4'b1111, 16'd0);
        check("s1_cycN_valid", 32'(a.RES_VALID), 32'd0);
        check("s1_cycN_busy", 32'(a.BUSY), 32'd1);
        step();
        check("s1_issue_bb_op", 32'(a.BB_OP), 32'hF);
        step();
        check("s1_wait_bb_op", 32'(a.BB_OP), 32'd0);
        check("s1_wait_valid", 32'(a.RES_VALID), 32'd0);
        step();
        check("s1_n3_valid", 32'(a.RES_VALID), 32'd1);
        take_result("s1_res", 32'd0, 2'b00);
        push_a(4'b0010, 16'd10);
        take_result("s1_add", 32'd10, 2'b00);

        // Scenario 2: MUL 15.
        push_a(4'b0100, 16'd15);
        take_result("s2_mul", 32'd150, 2'b00);

        // Scenario 3: error flags masked per opcode; DIV error halts.
        inj_err = 2'b11;
        push_a(4'b1111, 16'd0);
        push_a(4'b0101, 16'd7);
        push_a(4'b0010, 16'd1);
        take_result("s3_res", 32'd0, 2'b00);
        take_result("s3_div", 32'd0, 2'b10);
        inj_err = 2'b00;
        check("s3_halt", 32'(a.HALT), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a.BB_OP !== 4'b0000) seen = 1'b1;
            step();
        end
        check("s3_no_issue_halted", 32'(seen), 32'd0);
        check("s3_halt_held", 32'(a.HALT), 32'd1);
        check("s3_busy_halted", 32'(a.BUSY), 32'd1);
        a.CLR_HALT = 1'b1;
        step();
        a.CLR_HALT = 1'b0;
        check("s3_halt_cleared", 32'(a.HALT), 32'd0);
        take_result("s3_add", 32'd1, 2'b00);

        // Scenario 4: consumer stalled, fill the FIFO.
        accepted = 0;
        a.CMD_VALID = 1'b1;
        a.CMD_OP    = 4'b0010;
        a.CMD_IN1   = 16'd1;
        for (int i = 0; i < 10; i++) begin
            if (a.CMD_READY === 1'b1) accepted++;
            step();
        end
        a.CMD_VALID = 1'b0;
        check("s4_accepted", 32'(accepted), 32'd9);
        check("s4_cmd_ready", 32'(a.CMD_READY), 32'd0);
        check("s4_hold_valid", 32'(a.RES_VALID), 32'd1);
        check("s4_hold_data", a.RES_DATA, 32'd2);
        step();
        step();
        step();
        check("s4_hold_stable", a.RES_DATA, 32'd2);
        for (int i = 0; i < 9; i++) begin
            take_result($sformatf("s4_drain%0d", i), 32'(2 + i), 2'b00);
        end
        step();
        check("s4_idle_busy", 32'(a.BUSY), 32'd0);

        // Scenario 5: reset mid-WAIT discards the command.
        push_a(4'b0010, 16'd3);
        step();
        step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("s5_valid", 32'(a.RES_VALID), 32'd0);
        check("s5_bb_op", 32'(a.BB_OP), 32'd0);
        check("s5_busy", 32'(a.BUSY), 32'd0);
        check("s5_cmd_ready", 32'(a.CMD_READY), 32'd1);
        check("s5_res_data", a.RES_DATA, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (a.RES_VALID !== 1'b0) seen = 1'b1;
            step();
        end
        check("s5_no_result", 32'(seen), 32'd0);

        // Scenario 6: SETTLE=3 latency.
        b.CMD_VALID = 1'b1;
        b.CMD_OP    = 4'b1111;
        b.CMD_IN1   = 16'd0;
        step();
        b.CMD_VALID = 1'b0;
        b.RES_READY = 1'b1;
        for (int n = 0; n < 50 && b.BUSY === 1'b1; n++) step();
        check("s6_drained", 32'(b.BUSY), 32'd0);
        b.RES_READY = 1'b0;
        b.CMD_VALID = 1'b1;
        b.CMD_OP    = 4'b0010;
        b.CMD_IN1   = 16'd5;
        step();
        b.CMD_VALID = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (b.RES_VALID !== 1'b0) seen = 1'b1;
        end
        check("s6_early_valid", 32'(seen), 32'd0);
        step();
        check("s6_valid_n5", 32'(b.RES_VALID), 32'd1);
        check("s6_data", b.RES_DATA, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, sets the command FIFO depth in entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter SETTLE, default 1, sets the number of wait cycles between the issue cycle and result capture; it SHALL be in the range 1..7.
REQ-003 Ports (clock and reset first), one per line:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  host command valid.
- CMD_READY  out  1  command FIFO not full.
- CMD_OP  in  4  opcode of the command.
- CMD_IN1  in  16  operand of the command.
- BB_OP  out  4  opcode to the accumulator datapath.
- BB_IN1  out  16  operand to the accumulator datapath.
- BB_OUT  in  32  accumulator value returned by the datapath.
- BB_ERR  in  2  datapath error flags: [0] overflow, [1] divide-by-zero.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumer ready.
- RES_DATA  out  32  captured accumulator value.
- RES_ERR  out  2  masked error flags.
- BUSY  out  1  FIFO non-empty or FSM not in IDLE.
- HALT  out  1  sticky error-halt indicator.
- CLR_HALT  in  1  clears HALT.

Function
REQ-004 A command SHALL be pushed when CMD_VALID and CMD_READY are both high; CMD_READY SHALL equal !full, and a push while full SHALL be impossible.
REQ-005 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, HOLD and HALTED.
REQ-006 IDLE -> ISSUE SHALL occur when the FIFO is non-empty and HALT is 0; the head entry is popped on that edge.
REQ-007 In ISSUE, BB_OP and BB_IN1 SHALL carry the popped command for exactly one cycle; in all other states BB_OP SHALL be 0000 (no-op, accumulator holds) and BB_IN1 SHALL be 0.
REQ-008 ISSUE -> WAIT; WAIT SHALL last SETTLE cycles, and BB_OUT and BB_ERR SHALL be captured on the last WAIT edge, at which the FSM moves to HOLD.
REQ-009 Latency: for a push at edge N into an empty FIFO in IDLE, ISSUE SHALL be cycle N+1 and RES_VALID SHALL first be high in cycle N+2+SETTLE.
REQ-010 In HOLD, RES_VALID SHALL be 1 and RES_DATA/RES_ERR SHALL be stable until RES_READY is sampled high.
REQ-011 At most one command SHALL be in flight; no new ISSUE SHALL occur before the HOLD handshake completes.
REQ-012 RES_ERR[0] SHALL be BB_ERR[0] only for opcodes 0010/0011 and 0 otherwise.
REQ-013 RES_ERR[1] SHALL be BB_ERR[1] only for opcodes 0101/0110 and 0 otherwise.
REQ-014 HOLD exit SHALL go to HALTED if RES_ERR != 00, else to IDLE; HALT SHALL be 1 exactly in HALTED.
REQ-015 In HALTED, no command SHALL issue, while pushes SHALL still be accepted while the FIFO is not full.
REQ-016 CLR_HALT high in HALTED SHALL move the FSM to IDLE on the next edge; CLR_HALT SHALL be ignored in other states.
REQ-017 Push and pop on the same edge SHALL leave the FIFO count unchanged, and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-018 Opcodes 0111-1101 SHALL pass through unchanged and SHALL produce a result like any other opcode.

Reset
REQ-019 With RST high at an edge: FIFO emptied, FSM in IDLE, BB_OP=0000, BB_IN1=0, RES_VALID=0, RES_DATA=0, RES_ERR=00, HALT=0, BUSY=0, CMD_READY=1 from the next cycle.
REQ-020 RST SHALL take priority over all other inputs, including in mid-WAIT or mid-HOLD; any in-flight result SHALL be discarded.
REQ-021 The block SHALL NOT reset the external accumulator; the host issues opcode 1111 for that.

Structure
REQ-022 Shared package calc_pkg SHALL hold the opcode constants (NOP=0000, GND=0001, ADD=0010, SUB=0011, MUL=0100, DIV=0101, MOD=0110, PRE=1110, RES=1111), the FSM state enum, and the 20-bit command struct {op, in1}.
REQ-023 The FIFO SHALL be the sub-module calc_cmd_fifo, parameterised by DEPTH, with full, empty and count outputs.

Verification
REQ-024 Scenario 1: RST, then push 1111, then push ADD IN1=10 -> results 0 and 10, RES_ERR=00; first RES_VALID at cycle N+3 (SETTLE=1).
REQ-025 Scenario 2: after scenario 1, push MUL IN1=15 -> RES_DATA=150, RES_ERR=00.
REQ-026 Scenario 3: push 1111, DIV IN1=7, ADD IN1=1 -> DIV result RES_ERR=10, HALT=1, ADD not issued (BB_OP stays 0000); CLR_HALT -> ADD issues and yields 1.
REQ-027 Scenario 4: RES_READY held 0, push 10 commands (DEPTH=8) -> 1 issued, 8 buffered, CMD_READY=0, 10th not accepted, RES_DATA stable.
REQ-028 Scenario 5: RST asserted during WAIT -> next cycle RES_VALID=0, BB_OP=0000, BUSY=0, CMD_READY=1, and no result is ever delivered for that command.
REQ-029 Scenario 6: SETTLE=3, push ADD IN1=5 after 1111 -> RES_VALID exactly 5 cycles after the push edge, RES_DATA=5.
